mips_fetch_unit: RTL and testbench
==================================

Name: mips_fetch_unit

Overview:
Instruction-fetch front end for the team's multi-cycle 8-bit-datapath MIPS core. It sits directly upstream of the core's decode/execute FSM. It owns the instruction memory, which is loaded via a write port before a run. It prefetches sequential instructions into a small FIFO and presents them with a valid/ready handshake. Branch, jump and jr outcomes from the core arrive as a redirect, which flushes the prefetch path and restarts fetch at the target PC.

Parameters:
IMEM_DEPTH, 11, number of instruction words; equals the core's end-of-program PC
PC_W, 8, PC / address width
INST_W, 32, instruction word width
FIFO_DEPTH, 2, prefetch buffer entries (minimum 2)

Ports:
clk  input  1  clock; all state updates on its rising edge
rst_n  input  1  synchronous, active-low reset
load_en  input  1  write one instruction word
load_addr  input  PC_W  word address for load
load_data  input  INST_W  instruction word to store
start  input  1  begin fetching at PC 0
inst_valid  output  1  FIFO head is valid
inst_ready  input  1  core accepts the head this cycle
inst  output  INST_W  head instruction word
inst_pc  output  PC_W  PC of head instruction
redir_valid  input  1  core requests fetch redirect
redir_pc  input  PC_W  redirect target PC
done  output  1  fetch exhausted: PC >= IMEM_DEPTH, FIFO empty, nothing in flight

Behaviour:
- Reset (rst_n=0 at an edge): state=IDLE, fetch_pc=0, FIFO empty, inflight=0, inst_valid=0, inst=0, inst_pc=0, done=0. Memory contents are not cleared.
- FSM states:
  - IDLE: load_en with load_addr<IMEM_DEPTH writes mem[load_addr]; out-of-range loads are ignored. start moves to RUN. If load_en and start are both high, the write happens and the state moves to RUN.
  - RUN: load_en is ignored.
  - END: load_en is ignored.
- Read issue in RUN: when fetch_pc<IMEM_DEPTH and (fifo_count+inflight)<FIFO_DEPTH and no redirect:
  - register the address and set inflight=1;
  - fetch_pc<=fetch_pc+1.
- Memory read has 1-cycle latency. At the next edge the word and its PC are pushed into the FIFO and inflight clears, unless cancelled.
- Latency: start sampled at edge E0. First read issued at E1. inst_valid=1 with inst_pc=0 after E2.
- Throughput: with inst_ready held high, one instruction per cycle.
- Handshake:
  - A pop occurs on an edge where inst_valid&inst_ready.
  - inst and inst_pc are stable while inst_valid=1 and inst_ready=0.
  - Pop and push in the same cycle are both legal; the count is unchanged.
- Redirect (redir_valid=1 at an edge, RUN or END):
  - A same-cycle pop completes first.
  - The FIFO is then flushed, any in-flight read is cancelled (its data is dropped next cycle), and fetch_pc<=redir_pc.
  - State becomes RUN.
  - No read is issued on the redirect edge. The target instruction becomes valid 2 edges after the redirect edge.
  - Redirect has priority over push. It is ignored in IDLE.
- redir_pc>=IMEM_DEPTH: the FIFO is flushed, no reads are issued, and the state moves to END on the next edge.
- END: entered from RUN when fetch_pc>=IMEM_DEPTH, inflight=0 and the FIFO is empty. done=1 while in END; done is registered and goes high the edge after the conditions hold. A redirect leaves END and drops done.
- PC arithmetic is unsigned, modulo 2^PC_W; there is no wrap inside IMEM_DEPTH.
- Reset mid-run takes priority over everything: the FIFO and in-flight read are discarded and the state returns to IDLE.

Decomposition:
- Shared package mips_pkg holds:
  - opcode/funct constants (LW=35, ADDIU=9, BEQ=4, BNE=5, JAL=3, J=2, R-type funct ADDU=33, SLT=42, JR=8);
  - width constants PC_W=8, INST_W=32, DATA_W=8;
  - the fetch FSM state enum (IDLE, RUN, END).
- One sub-module, mips_fetch_fifo: a synchronous FIFO of {pc, inst} with push, pop, flush, count, and full/empty flags.

Test Plan:
1. Load 11 words (for example mem[k]=32'h0000_0100+k), then start with inst_ready=1 → inst_pc 0..10 appear on consecutive cycles from E2 with matching inst; done=1 about 1 cycle after the last pop.
2. After inst_pc=3 is valid, hold inst_ready=0 for 5 cycles → inst_pc stays 3; fifo_count never exceeds 2; release → sequence continues 3,4,5 with no gap or duplicate.
3. With inst_pc=5 at the head and a read in flight, pulse redir_pc=8 → next valid inst_pc=8 exactly 2 edges later; PCs 6 and 7 never appear.
4. redir_valid and an inst_ready pop in the same cycle with head pc=2, redir_pc=2 → pc 2 is consumed once, then pc 2 is refetched, valid 2 edges later.
5. In RUN, redir_pc=20 → inst_valid=0 next cycle and done=1 within 2 edges. A subsequent redir_pc=0 → done=0 and inst_pc=0 is valid 2 edges later.
6. Drive rst_n=0 for one edge while the FIFO is full → inst_valid=0, done=0, state IDLE. Memory is retained, so start refetches from PC 0 with the identical words.

Source files
------------

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared MIPS core constants, widths and fetch FSM state type
package mips_pkg;

    localparam int PC_W   = 8;
    localparam int INST_W = 32;
    localparam int DATA_W = 8;

    localparam logic [5:0] OP_LW    = 6'd35;
    localparam logic [5:0] OP_ADDIU = 6'd9;
    localparam logic [5:0] OP_BEQ   = 6'd4;
    localparam logic [5:0] OP_BNE   = 6'd5;
    localparam logic [5:0] OP_JAL   = 6'd3;
    localparam logic [5:0] OP_J     = 6'd2;

    localparam logic [5:0] FN_ADDU  = 6'd33;
    localparam logic [5:0] FN_SLT   = 6'd42;
    localparam logic [5:0] FN_JR    = 6'd8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_END  = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/mips_fetch_fifo.sv
// rtl/mips_fetch_fifo.sv - synchronous prefetch FIFO of {pc, inst} entries
module mips_fetch_fifo #(
    parameter int W     = 40,
    parameter int DEPTH = 2,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [W-1:0]     push_data,
    input  logic             pop,
    input  logic             flush,
    output logic [W-1:0]     head_data,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]     slots [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty     = (count == '0);
    assign full      = (count == CNT_W'(DEPTH));
    assign do_pop    = pop && !empty;
    // A full FIFO still accepts a push when the head leaves on the same edge.
    assign do_push   = push && (!full || do_pop);
    assign head_data = slots[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                slots[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                slots[wr_ptr] <= push_data;
                wr_ptr        <= next_ptr(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mips_fetch_unit.sv
// rtl/mips_fetch_unit.sv - instruction memory, prefetch and redirect front end
module mips_fetch_unit #(
    parameter int IMEM_DEPTH = 11,
    parameter int PC_W       = mips_pkg::PC_W,
    parameter int INST_W     = mips_pkg::INST_W,
    parameter int FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_en,
    input  logic [PC_W-1:0]   load_addr,
    input  logic [INST_W-1:0] load_data,
    input  logic              start,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [INST_W-1:0] inst,
    output logic [PC_W-1:0]   inst_pc,
    input  logic              redir_valid,
    input  logic [PC_W-1:0]   redir_pc,
    output logic              done
);

    import mips_pkg::*;

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int AW    = (IMEM_DEPTH > 1) ? $clog2(IMEM_DEPTH) : 1;
    localparam logic [PC_W-1:0] END_PC   = PC_W'(IMEM_DEPTH);
    localparam logic [CNT_W:0]  FIFO_CAP = (CNT_W + 1)'(FIFO_DEPTH);

    fetch_state_t state;
    fetch_state_t state_next;

    logic [INST_W-1:0]      mem [IMEM_DEPTH];
    logic [PC_W-1:0]        fetch_pc;
    logic [PC_W-1:0]        rd_pc;
    logic                   inflight;
    logic                   done_q;

    logic                   redirect;
    logic                   issue;
    logic                   load_write;
    logic                   fifo_push;
    logic                   fifo_pop;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [CNT_W-1:0]       fifo_count;
    logic [PC_W+INST_W-1:0] head;
    logic [CNT_W:0]         occupancy;

    // Entries already committed to the FIFO after this edge; counting the pop
    // lets a new read go out every cycle while the core drains at full rate.
    assign fifo_pop  = inst_valid && inst_ready;
    assign occupancy = {1'b0, fifo_count} + {{CNT_W{1'b0}}, inflight}
                     - {{CNT_W{1'b0}}, fifo_pop};

    always_comb begin
        state_next = state;
        redirect   = 1'b0;
        issue      = 1'b0;
        load_write = 1'b0;
        unique case (state)
            ST_IDLE: begin
                load_write = load_en && (load_addr < END_PC);
                if (start) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN, ST_END: begin
                if (redir_valid) begin
                    redirect   = 1'b1;
                    state_next = ST_RUN;
                end else if (state == ST_RUN) begin
                    issue = (fetch_pc < END_PC) && (occupancy < FIFO_CAP);
                    if ((fetch_pc >= END_PC) && !inflight && fifo_empty) begin
                        state_next = ST_END;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign fifo_push = inflight && !redirect;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            done_q <= 1'b0;
        end else begin
            state  <= state_next;
            done_q <= (state_next == ST_END);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_pc <= '0;
            rd_pc    <= '0;
            inflight <= 1'b0;
        end else if (redirect) begin
            fetch_pc <= redir_pc;
            inflight <= 1'b0;
        end else begin
            inflight <= issue;
            if (issue) begin
                rd_pc    <= fetch_pc;
                fetch_pc <= fetch_pc + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && load_write) begin
            mem[load_addr[AW-1:0]] <= load_data;
        end
    end

    mips_fetch_fifo #(
        .W     (PC_W + INST_W),
        .DEPTH (FIFO_DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (fifo_push),
        .push_data ({rd_pc, mem[rd_pc[AW-1:0]]}),
        .pop       (fifo_pop),
        .flush     (redirect),
        .head_data (head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign inst_valid = !fifo_empty;
    assign inst       = head[INST_W-1:0];
    assign inst_pc    = head[PC_W+INST_W-1:INST_W];
    assign done       = done_q;

endmodule

// File: tb/tb_mips_fetch_unit.sv
// tb/tb_mips_fetch_unit.sv - directed self-checking bench for mips_fetch_unit
module tb_mips_fetch_unit;

    import mips_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        load_en;
    logic [7:0]  load_addr;
    logic [31:0] load_data;
    logic        start;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [7:0]  inst_pc;
    logic        redir_valid;
    logic [7:0]  redir_pc;
    logic        done;

    int checks = 0;
    int errors = 0;

    mips_fetch_unit dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_en     (load_en),
        .load_addr   (load_addr),
        .load_data   (load_data),
        .start       (start),
        .inst_valid  (inst_valid),
        .inst_ready  (inst_ready),
        .inst        (inst),
        .inst_pc     (inst_pc),
        .redir_valid (redir_valid),
        .redir_pc    (redir_pc),
        .done        (done)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] word(input int k);
        return 32'h0000_0100 + 32'(k);
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_head(input string tag, input int pc);
        check({tag, "_valid"}, 64'(inst_valid), 64'd1);
        check({tag, "_pc"}, 64'(inst_pc), 64'(pc));
        check({tag, "_inst"}, 64'(inst), 64'(word(pc)));
    endtask

    task automatic redirect_to(input logic [7:0] pc);
        redir_valid = 1'b1;
        redir_pc    = pc;
        step();
        redir_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; load_en = 1'b0; load_addr = '0; load_data = '0;
        start = 1'b0; inst_ready = 1'b0; redir_valid = 1'b0; redir_pc = '0;
        step();
        step();
        check("rst_valid", 64'(inst_valid), 64'd0);
        check("rst_inst", 64'(inst), 64'd0);
        check("rst_pc", 64'(inst_pc), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        rst_n = 1'b1;

        for (int k = 0; k < 11; k++) begin
            load_en = 1'b1; load_addr = 8'(k); load_data = word(k);
            step();
        end
        // Out-of-range address whose low bits alias word 8: must be ignored.
        load_addr = 8'd24; load_data = 32'hDEAD_BEEF;
        step();
        load_en = 1'b0;

        // Test 1: streaming run with exact start latency
        inst_ready = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        check("t1_e0_valid", 64'(inst_valid), 64'd0);
        step();
        check("t1_e1_valid", 64'(inst_valid), 64'd0);
        step();
        for (int k = 0; k < 11; k++) begin
            check_head($sformatf("t1_k%0d", k), k);
            step();
        end
        check("t1_drained", 64'(inst_valid), 64'd0);
        for (int n = 0; n < 3 && !done; n++) step();
        check("t1_done", 64'(done), 64'd1);

        // Test 2: stall at pc 3 then resume, restarting from END
        redirect_to(8'd0);
        check("t2_done_drop", 64'(done), 64'd0);
        step();
        step();
        for (int k = 0; k < 3; k++) begin
            check_head($sformatf("t2_k%0d", k), k);
            step();
        end
        check_head("t2_pc3", 3);
        inst_ready = 1'b0;
        for (int n = 0; n < 5; n++) begin
            step();
            check_head($sformatf("t2_stall%0d", n), 3);
            check($sformatf("t2_cnt%0d", n), 64'(dut.fifo_count <= 2), 64'd1);
        end
        inst_ready = 1'b1;
        step();
        check_head("t2_pc4", 4);
        step();
        check_head("t2_pc5", 5);
        check("t2_inflight", 64'(dut.inflight), 64'd1);

        // Test 3: redirect with a read in flight
        redirect_to(8'd8);
        check("t3_r0_valid", 64'(inst_valid), 64'd0);
        step();
        check("t3_r1_valid", 64'(inst_valid), 64'd0);
        step();
        check_head("t3_pc8", 8);
        step();
        check_head("t3_pc9", 9);

        // Test 4: redirect and pop on the same edge
        redirect_to(8'd2);
        step();
        step();
        check_head("t4_head2", 2);
        redirect_to(8'd2);
        check("t4_r0_valid", 64'(inst_valid), 64'd0);
        step();
        check("t4_r1_valid", 64'(inst_valid), 64'd0);
        step();
        check_head("t4_refetch2", 2);
        step();
        check_head("t4_pc3", 3);

        // Test 5: out-of-range redirect then recovery
        redirect_to(8'd20);
        check("t5_valid", 64'(inst_valid), 64'd0);
        check("t5_done_early", 64'(done), 64'd0);
        step();
        check("t5_done", 64'(done), 64'd1);
        check("t5_valid2", 64'(inst_valid), 64'd0);
        redirect_to(8'd0);
        check("t5_done_drop", 64'(done), 64'd0);
        step();
        step();
        check_head("t5_pc0", 0);

        // Test 6: reset with a full FIFO, memory retained
        inst_ready = 1'b0;
        step();
        check("t6_full", 64'(dut.fifo_count), 64'd2);
        check_head("t6_head0", 0);
        rst_n = 1'b0;
        step();
        check("t6_valid", 64'(inst_valid), 64'd0);
        check("t6_done", 64'(done), 64'd0);
        check("t6_state", 64'(dut.state), 64'(ST_IDLE));
        rst_n = 1'b1;
        inst_ready = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        check("t6_e0_valid", 64'(inst_valid), 64'd0);
        step();
        step();
        for (int k = 0; k < 3; k++) begin
            check_head($sformatf("t6_k%0d", k), k);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
